hi_lo_unit: RTL and testbench



---
 rtl/hi_lo_unit.sv | 102 ++++++++++
 tb/tb_hi_lo_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hi_lo_unit.sv
// HI/LO register unit: MULT, MTHI, MTLO and, when HILO_ACCUM_EN is defined, two-cycle MADD/MSUB
// accumulate into the 64-bit {HI,LO} pair. Without HILO_ACCUM_EN, opcodes 100/101 act as NOP.
module hi_lo_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        OpValid,
  input  logic [2:0]  Op,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUHiResult,
  input  logic [31:0] RsData,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Busy,
  output logic        Accepted
);

  localparam logic [2:0] OpMult = 3'b001;
  localparam logic [2:0] OpMthi = 3'b010;
  localparam logic [2:0] OpMtlo = 3'b011;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy;

`ifdef HILO_ACCUM_EN
  localparam logic [2:0] OpMadd = 3'b100;
  localparam logic [2:0] OpMsub = 3'b101;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e      state_q, state_d;
  logic [63:0] prod_q, prod_d;
  logic        sub_q, sub_d;
  logic [63:0] acc_result;

  assign busy       = (state_q == StAccum);
  // Full 64-bit add/sub so the carry/borrow crosses from LO into HI; overflow wraps.
  assign acc_result = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
`else
  assign busy = 1'b0;
`endif

  assign Busy     = busy;
  assign Accepted = OpValid && !busy;
  assign HiOut    = hi_q;
  assign LoOut    = lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
`ifdef HILO_ACCUM_EN
    state_d = state_q;
    prod_d  = prod_q;
    sub_d   = sub_q;
    if (state_q == StAccum) begin
      {hi_d, lo_d} = acc_result;
      state_d      = StIdle;
    end
`endif
    // Accepted is never high in the accumulate cycle, so the two updates cannot collide.
    if (Accepted) begin
      case (Op)
        OpMult: {hi_d, lo_d} = {ALUHiResult, ALUResult};
        OpMthi: hi_d = RsData;
        OpMtlo: lo_d = RsData;
`ifdef HILO_ACCUM_EN
        OpMadd, OpMsub: begin
          prod_d  = {ALUHiResult, ALUResult};
          sub_d   = (Op == OpMsub);
          state_d = StAccum;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef HILO_ACCUM_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      prod_q  <= 64'h0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
    end
  end
`endif

endmodule

// File: tb/tb_hi_lo_unit.sv
// Scoreboard bench for hi_lo_unit: the driver pushes expected outputs from a 64-bit arithmetic
// model; a monitor pops and compares once per cycle. Honours HILO_ACCUM_EN like the design.
module tb_hi_lo_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        OpValid = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] ALUResult = '0;
  logic [31:0] ALUHiResult = '0;
  logic [31:0] RsData = '0;
  logic [31:0] HiOut, LoOut;
  logic        Busy, Accepted;

  hi_lo_unit dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .OpValid    (OpValid),
    .Op         (Op),
    .ALUResult  (ALUResult),
    .ALUHiResult(ALUHiResult),
    .RsData     (RsData),
    .HiOut      (HiOut),
    .LoOut      (LoOut),
    .Busy       (Busy),
    .Accepted   (Accepted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    bit          chk;
    logic [63:0] acc;
    logic        busy;
    logic        accepted;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural model: the HI:LO pair as one 64-bit number plus a pending accumulate.
  logic [63:0] m_acc     = '0;
  bit          m_pending = 1'b0;
  logic [63:0] m_prod    = '0;
  bit          m_sub     = 1'b0;
  bit          m_known   = 1'b0;

  // One cycle: present inputs just after a rising edge, record what the monitor should see
  // this cycle, then advance the model across the next edge.
  task automatic drive(input bit rst, input bit vld, input logic [2:0] op,
                       input logic [31:0] ahi, input logic [31:0] alo,
                       input logic [31:0] rs, input string name);
    exp_t e;
    bit   acc_now;
    @(posedge Clk);
    #1;
    Rst = rst; OpValid = vld; Op = op; ALUHiResult = ahi; ALUResult = alo; RsData = rs;
    acc_now    = vld && !m_pending;
    e.name     = name;
    e.chk      = m_known;
    e.acc      = m_acc;
    e.busy     = m_pending;
    e.accepted = acc_now;
    sb.push_back(e);
    if (rst) begin
      m_acc = '0; m_pending = 0; m_prod = '0; m_sub = 0; m_known = 1;
    end else if (m_pending) begin
      m_acc     = m_sub ? m_acc - m_prod : m_acc + m_prod;
      m_pending = 0;
    end else if (acc_now) begin
      case (op)
        3'd1: m_acc = {ahi, alo};
        3'd2: m_acc[63:32] = rs;
        3'd3: m_acc[31:0] = rs;
`ifdef HILO_ACCUM_EN
        3'd4, 3'd5: begin
          m_prod = {ahi, alo}; m_sub = (op == 3'd5); m_pending = 1;
        end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input string what, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h, expected %h", name, what, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check(e.name, "HiOut", {32'h0, HiOut}, {32'h0, e.acc[63:32]});
          check(e.name, "LoOut", {32'h0, LoOut}, {32'h0, e.acc[31:0]});
          check(e.name, "Busy", {63'h0, Busy}, {63'h0, e.busy});
          check(e.name, "Accepted", {63'h0, Accepted}, {63'h0, e.accepted});
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] rop;
    drive(1, 0, 3'd0, '0, '0, '0, "reset0");
    drive(1, 0, 3'd0, '0, '0, '0, "reset1");
    drive(0, 0, 3'd0, '0, '0, '0, "idle");
    // MULT
    drive(0, 1, 3'd1, 32'h00000001, 32'hFFFFFFFE, '0, "mult");
    drive(0, 0, 3'd0, '0, '0, '0, "mult_res");
    // MTHI then MTLO
    drive(0, 1, 3'd2, '0, '0, 32'hDEADBEEF, "mthi");
    drive(0, 1, 3'd3, '0, '0, 32'h12345678, "mtlo");
    drive(0, 0, 3'd0, '0, '0, '0, "mtx_res");
    // MADD with carry out of LO, MTLO attempted during the busy cycle
    drive(0, 1, 3'd1, 32'h0, 32'hFFFFFFFF, '0, "madd_setup");
    drive(0, 1, 3'd4, 32'h0, 32'h00000001, '0, "madd");
    drive(0, 1, 3'd3, '0, '0, 32'hCAFEF00D, "madd_busy_mtlo");
    drive(0, 0, 3'd0, '0, '0, '0, "madd_res");
    // MSUB wrap and back-to-back MSUB
    drive(0, 1, 3'd1, 32'h0, 32'h0, '0, "msub_setup");
    drive(0, 1, 3'd5, 32'h0, 32'h00000001, '0, "msub");
    drive(0, 1, 3'd5, 32'h0, 32'h00000002, '0, "msub_held");
    drive(0, 1, 3'd5, 32'h0, 32'h00000002, '0, "msub2");
    drive(0, 0, 3'd0, '0, '0, '0, "msub2_wait");
    drive(0, 0, 3'd0, '0, '0, '0, "msub2_res");
    // Reset during the accumulate cycle
    drive(0, 1, 3'd1, 32'h11111111, 32'h22222222, '0, "rst_setup");
    drive(0, 1, 3'd4, 32'h00000003, 32'h00000004, '0, "rst_madd");
    drive(1, 1, 3'd1, 32'h55555555, 32'h66666666, '0, "rst_in_accum");
    drive(0, 0, 3'd0, '0, '0, '0, "rst_res");
    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rop = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rop,
            $urandom, $urandom, $urandom, "random");
    end
    drive(1, 1, 3'd1, $urandom, $urandom, $urandom, "final_rst0");
    drive(1, 0, 3'd0, '0, '0, '0, "final_rst1");
    drive(0, 0, 3'd0, '0, '0, '0, "final_idle");
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    check("drain", "pending", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
